// File: rtl/adam_axil_ram_slv.sv
// AXI-Lite single-beat responder backed by a word-organised on-chip RAM.
// Define ADAM_AXIL_RAM_SLV_PAUSE_EN to add the pause_req/pause_ack quiesce handshake.
module adam_axil_ram_slv #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 1024
) (
  input  logic                    clk,
  input  logic                    rst,

  input  logic [ADDR_WIDTH-1:0]   aw_addr,
  input  logic                    aw_valid,
  output logic                    aw_ready,

  input  logic [DATA_WIDTH-1:0]   w_data,
  input  logic [DATA_WIDTH/8-1:0] w_strb,
  input  logic                    w_valid,
  output logic                    w_ready,

  output logic [1:0]              b_resp,
  output logic                    b_valid,
  input  logic                    b_ready,

  input  logic [ADDR_WIDTH-1:0]   ar_addr,
  input  logic                    ar_valid,
  output logic                    ar_ready,

  output logic [DATA_WIDTH-1:0]   r_data,
  output logic [1:0]              r_resp,
  output logic                    r_valid,
  input  logic                    r_ready
`ifdef ADAM_AXIL_RAM_SLV_PAUSE_EN
  ,
  input  logic                    pause_req,
  output logic                    pause_ack
`endif
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam longint unsigned MEM_BYTES = longint'(DEPTH) * longint'(STRB_W);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {IDLE, WRESP, RRESP} state_t;

  state_t                state;
  logic                  prio_write;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic             pause_hold;
  logic             wr_elig, rd_elig;
  logic             grant_w, grant_r;
  logic             aw_ok, ar_ok;
  logic [IDX_W-1:0] aw_idx, ar_idx;

`ifdef ADAM_AXIL_RAM_SLV_PAUSE_EN
  assign pause_hold = pause_req;
`else
  assign pause_hold = 1'b0;
`endif

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] addr);
    return 64'(addr) < MEM_BYTES;
  endfunction

  assign aw_ok  = in_range(aw_addr);
  assign ar_ok  = in_range(ar_addr);
  assign aw_idx = aw_addr[OFF_W +: IDX_W];
  assign ar_idx = ar_addr[OFF_W +: IDX_W];

  // A write needs AW and W together; on a tie the channel served last yields.
  assign wr_elig = (state == IDLE) && !pause_hold && aw_valid && w_valid;
  assign rd_elig = (state == IDLE) && !pause_hold && ar_valid;
  assign grant_w = wr_elig && (!rd_elig || prio_write);
  assign grant_r = rd_elig && (!wr_elig || !prio_write);

  // NOTE: readies are combinational so the grant and the handshake share one cycle.
  assign aw_ready = grant_w;
  assign w_ready  = grant_w;
  assign ar_ready = grant_r;

  // NOTE: the RAM array has no reset so it maps onto block memory; contents survive rst.
  always_ff @(posedge clk) begin
    if (grant_w && aw_ok) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (w_strb[i]) mem[aw_idx][i*8 +: 8] <= w_data[i*8 +: 8];
      end
    end
  end

  // NOTE: all sequential state uses non-blocking assignment so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      prio_write <= 1'b1;
      b_valid    <= 1'b0;
      b_resp     <= RESP_OKAY;
      r_valid    <= 1'b0;
      r_resp     <= RESP_OKAY;
      r_data     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_w) begin
            b_resp     <= aw_ok ? RESP_OKAY : RESP_SLVERR;
            b_valid    <= 1'b1;
            prio_write <= 1'b0;
            state      <= WRESP;
          end else if (grant_r) begin
            r_data     <= ar_ok ? mem[ar_idx] : '0;
            r_resp     <= ar_ok ? RESP_OKAY : RESP_SLVERR;
            r_valid    <= 1'b1;
            prio_write <= 1'b1;
            state      <= RRESP;
          end
        end
        WRESP: begin
          if (b_ready) begin
            b_valid <= 1'b0;
            state   <= IDLE;
          end
        end
        RRESP: begin
          if (r_ready) begin
            r_valid <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ADAM_AXIL_RAM_SLV_PAUSE_EN
  // Acknowledge only once idle; comes out of reset paused.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pause_ack <= 1'b1;
    else     pause_ack <= pause_req && (pause_ack || (state == IDLE));
  end
`endif

endmodule
